// File: rtl/serial_uint_add.sv
// Bit-serial unsigned adder, DIGIT bits per cycle LSB first: O = I0 + I1 mod 2^WIDTH.
// Optional carry-out port enabled by defining SERIAL_ADD_COUT_EN.
module serial_uint_add #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O,
    output logic             O_valid,
`ifdef SERIAL_ADD_COUT_EN
    output logic             COUT,
`endif
    input  logic             O_ready
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_uint_add: WIDTH must be a non-zero multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res, res_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             load, step, last;
    logic [DIGIT:0]   dsum;

    assign dsum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign last = (cnt == CW'(NDIG - 1));

    // Sum digits enter at the MSB end so the result is aligned after NDIG steps.
    if (DIGIT == WIDTH) begin : g_one_digit
        assign res_nxt = dsum[DIGIT-1:0];
    end else begin : g_multi_digit
        assign res_nxt = {dsum[DIGIT-1:0], res[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        I_ready   = 1'b0;
        O_valid   = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                I_ready = 1'b1;
                if (I_valid) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                O_valid = 1'b1;
                if (O_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sr  <= I0;
            b_sr  <= I1;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (step) begin
            a_sr  <= a_sr >> DIGIT;
            b_sr  <= b_sr >> DIGIT;
            res   <= res_nxt;
            carry <= dsum[DIGIT];
            cnt   <= cnt + 1'b1;
        end
    end

    assign O = res;

`ifdef SERIAL_ADD_COUT_EN
    assign COUT = carry;
`endif

endmodule

// File: tb/tb_serial_uint_add.sv
// Randomized self-checking bench for serial_uint_add at DIGIT = 1, 4 and 8 (WIDTH = 8),
// with a plain-arithmetic reference; honours SERIAL_ADD_COUT_EN when defined.
module tb_serial_uint_add;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_in, b_in;
    logic       iv   [NDUT];
    logic       ordy [NDUT];
    logic       ir   [NDUT];
    logic       ov   [NDUT];
    logic [7:0] o    [NDUT];
`ifdef SERIAL_ADD_COUT_EN
    logic       co   [NDUT];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_uint_add #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .CLK(clk), .ASYNCRESET(rst), .I0(a_in), .I1(b_in),
        .I_valid(iv[0]), .I_ready(ir[0]), .O(o[0]), .O_valid(ov[0]),
`ifdef SERIAL_ADD_COUT_EN
        .COUT(co[0]),
`endif
        .O_ready(ordy[0])
    );

    serial_uint_add #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .CLK(clk), .ASYNCRESET(rst), .I0(a_in), .I1(b_in),
        .I_valid(iv[1]), .I_ready(ir[1]), .O(o[1]), .O_valid(ov[1]),
`ifdef SERIAL_ADD_COUT_EN
        .COUT(co[1]),
`endif
        .O_ready(ordy[1])
    );

    serial_uint_add #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .CLK(clk), .ASYNCRESET(rst), .I0(a_in), .I1(b_in),
        .I_valid(iv[2]), .I_ready(ir[2]), .O(o[2]), .O_valid(ov[2]),
`ifdef SERIAL_ADD_COUT_EN
        .COUT(co[2]),
`endif
        .O_ready(ordy[2])
    );

    // Cycles per operation for each instance: WIDTH / DIGIT.
    function automatic int ndig(input int d);
        return (d == 0) ? 8 : (d == 1) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction on instance d; called at posedge+1 with the instance idle.
    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input int bp);
        logic [8:0] full;
        logic [7:0] exp_o;
        int         n;
        full  = {1'b0, a} + {1'b0, b};
        exp_o = full[7:0];
        check("accept_ready", 32'(ir[d]), 32'd1);
        a_in    = a;
        b_in    = b;
        iv[d]   = 1'b1;
        ordy[d] = (bp == 0);
        @(posedge clk); #1;
        n = 0;
        while (!ov[d] && n < 64) begin
            check("busy_ready", 32'(ir[d]), 32'd0);
            iv[d] = 1'($urandom_range(0, 1));
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        iv[d] = 1'b0;
        check("latency", 32'(n), 32'(ndig(d)));
        check("sum", 32'(o[d]), 32'(exp_o));
`ifdef SERIAL_ADD_COUT_EN
        check("cout", 32'(co[d]), 32'(full[8]));
`endif
        check("done_ready", 32'(ir[d]), 32'd0);
        for (int i = 0; i < bp; i++) begin
            iv[d] = 1'b1;
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(ov[d]), 32'd1);
            check("hold_sum", 32'(o[d]), 32'(exp_o));
            check("hold_ready", 32'(ir[d]), 32'd0);
`ifdef SERIAL_ADD_COUT_EN
            check("hold_cout", 32'(co[d]), 32'(full[8]));
`endif
        end
        iv[d]   = 1'b0;
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        check("drop_valid", 32'(ov[d]), 32'd0);
        check("idle_ready", 32'(ir[d]), 32'd1);
        check("o_kept", 32'(o[d]), 32'(exp_o));
        ordy[d] = 1'b0;
    endtask

    task automatic reset_mid_busy();
        a_in    = 8'h5A;
        b_in    = 8'h33;
        iv[0]   = 1'b1;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("rst_o", 32'(o[0]), 32'd0);
        check("rst_valid", 32'(ov[0]), 32'd0);
        check("rst_ready", 32'(ir[0]), 32'd1);
        ordy[0] = 1'b0;
        @(posedge clk); #1;
        run_op(0, 8'd77, 8'd99, 0);
    endtask

    task automatic stream_test();
        logic [7:0] qa [$];
        logic [7:0] qb [$];
        logic [7:0] outs [$];
        int         acc_edge [$];
        int         k;
        int         edges;
        logic       acc;
        logic       hs;
        qa = '{8'd1, 8'd2, 8'd200};
        qb = '{8'd1, 8'd2, 8'd100};
        k     = 0;
        edges = 0;
        a_in    = qa[0];
        b_in    = qb[0];
        iv[0]   = 1'b1;
        ordy[0] = 1'b1;
        while (outs.size() < 3 && edges < 100) begin
            acc = iv[0] && ir[0];
            hs  = ov[0] && ordy[0];
            if (hs) outs.push_back(o[0]);
            @(posedge clk); #1;
            edges++;
            if (acc) begin
                acc_edge.push_back(edges);
                k++;
                if (k < 3) begin
                    a_in = qa[k];
                    b_in = qb[k];
                end else begin
                    iv[0] = 1'b0;
                end
            end
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;
        check("stream_outs", 32'(outs.size()), 32'd3);
        check("stream_accepts", 32'(k), 32'd3);
        for (int i = 0; i < outs.size(); i++) begin
            check("stream_sum", 32'(outs[i]), 32'((32'(qa[i]) + 32'(qb[i])) % 256));
        end
        for (int i = 1; i < acc_edge.size(); i++) begin
            check("stream_gap", 32'(acc_edge[i] - acc_edge[i-1]), 32'(ndig(0) + 2));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        a_in = '0;
        b_in = '0;
        for (int d = 0; d < NDUT; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b0;
        end
        #12;
        rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check("reset_o", 32'(o[d]), 32'd0);
            check("reset_valid", 32'(ov[d]), 32'd0);
            check("reset_ready", 32'(ir[d]), 32'd1);
`ifdef SERIAL_ADD_COUT_EN
            check("reset_cout", 32'(co[d]), 32'd0);
`endif
        end
        @(posedge clk); #1;

        run_op(0, 8'd3, 8'd5, 0);
        run_op(0, 8'd255, 8'd1, 0);
        run_op(1, 8'hA7, 8'h3C, 0);
        run_op(2, 8'hA7, 8'h3C, 0);
        run_op(2, 8'd255, 8'd255, 2);
        run_op(0, 8'h80, 8'h80, 5);
        run_op(1, 8'hFF, 8'h01, 5);
        run_op(0, 8'd0, 8'd0, 0);

        reset_mid_busy();
        stream_test();

        for (int i = 0; i < 24; i++) begin
            run_op(i % NDUT, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
